// File: rtl/draw_menu_if.sv
// vga_if: one VGA timing/pixel stream as produced by the timing generator.
//   hcount/vcount : 11-bit pixel counters (1344x806 total, 1024x768 active)
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : {r,g,b}, 4 bits each
// The "source" modport drives the stream. The "sink" modport receives it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport source (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport sink   (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_menu.sv
// draw_menu: overlays the scaled title/menu picture on a VGA stream.
//   clk        : pixel clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   start_game : 1 = game running, the picture is suppressed (pass-through)
//   rgb_pixel  : image ROM data, valid one clock after pixel_addr
//   pixel_addr : image ROM address {y_img, x_img}
//   in         : incoming VGA stream
//   out        : the same stream delayed by exactly two clocks, with the picture applied
//
// Stage 1 registers the stream and issues the ROM address.
// Stage 2 registers the stream again. The ROM answers during stage 2, so the rgb
// select is a mux of the stage-2 copies and rgb_pixel. This keeps every field at
// the same two-clock latency.
module draw_menu #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 96,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_game,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  vga_if.sink               in,
  vga_if.source             out
);

  localparam int          XW    = $clog2(IMG_W);
  localparam logic [10:0] X_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] Y_MAX = 11'(IMG_H - 1);
  localparam logic [10:0] H_PIX = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0] V_PIX = 11'(IMG_H << SCALE_SHIFT);

  // Address generation. Image coordinates are saturated to the image size.
  // This keeps the address inside the ROM even during blanking.
  logic [10:0]       x_img;
  logic [10:0]       y_img;
  logic [10:0]       x_clamp;
  logic [10:0]       y_clamp;
  logic [ADDR_W-1:0] addr_next;
  logic              in_img_next;

  always_comb begin
    x_img       = in.hcount >> SCALE_SHIFT;
    y_img       = in.vcount >> SCALE_SHIFT;
    x_clamp     = (x_img > X_MAX) ? X_MAX : x_img;
    y_clamp     = (y_img > Y_MAX) ? Y_MAX : y_img;
    addr_next   = (ADDR_W'(y_clamp) << XW) | ADDR_W'(x_clamp);
    in_img_next = (in.hcount < H_PIX) && (in.vcount < V_PIX);
  end

  // Stage 1
  logic [10:0] s1_hcount;
  logic [10:0] s1_vcount;
  logic        s1_hsync;
  logic        s1_vsync;
  logic        s1_hblnk;
  logic        s1_vblnk;
  logic [11:0] s1_rgb;
  logic        s1_in_img;
  logic        s1_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_img  <= 1'b0;
      s1_start   <= 1'b0;
      pixel_addr <= '0;
    end else begin
      s1_hcount  <= in.hcount;
      s1_vcount  <= in.vcount;
      s1_hsync   <= in.hsync;
      s1_vsync   <= in.vsync;
      s1_hblnk   <= in.hblnk;
      s1_vblnk   <= in.vblnk;
      s1_rgb     <= in.rgb;
      s1_in_img  <= in_img_next;
      // start_game travels with its pixel, so a mid-frame switch lands on a pixel boundary.
      s1_start   <= start_game;
      pixel_addr <= addr_next;
    end
  end

  // Stage 2
  logic [10:0] s2_hcount;
  logic [10:0] s2_vcount;
  logic        s2_hsync;
  logic        s2_vsync;
  logic        s2_hblnk;
  logic        s2_vblnk;
  logic [11:0] s2_rgb;
  logic        s2_in_img;
  logic        s2_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_hcount <= '0;
      s2_vcount <= '0;
      s2_hsync  <= 1'b0;
      s2_vsync  <= 1'b0;
      s2_hblnk  <= 1'b0;
      s2_vblnk  <= 1'b0;
      s2_rgb    <= '0;
      s2_in_img <= 1'b0;
      s2_start  <= 1'b0;
    end else begin
      s2_hcount <= s1_hcount;
      s2_vcount <= s1_vcount;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
      s2_hblnk  <= s1_hblnk;
      s2_vblnk  <= s1_vblnk;
      s2_rgb    <= s1_rgb;
      s2_in_img <= s1_in_img;
      s2_start  <= s1_start;
    end
  end

  // Colour select. rgb_pixel belongs to the pixel now in stage 2.
  // After reset every stage-2 flag is clear, so rgb is 0.
  logic [11:0] rgb_sel;

  always_comb begin
    rgb_sel = s2_rgb;
    if (s2_hblnk || s2_vblnk) begin
      rgb_sel = 12'h000;
    end else if (s2_start) begin
      rgb_sel = s2_rgb;
    end else if (s2_in_img) begin
      rgb_sel = rgb_pixel;
    end
  end

  assign out.hcount = s2_hcount;
  assign out.vcount = s2_vcount;
  assign out.hsync  = s2_hsync;
  assign out.vsync  = s2_vsync;
  assign out.hblnk  = s2_hblnk;
  assign out.vblnk  = s2_vblnk;
  assign out.rgb    = rgb_sel;

endmodule

// File: tb/tb_draw_menu.sv
// tb_draw_menu: randomized and directed stimulus for draw_menu.
// The reference model holds a queue of the last two sampled input pixels.
// The expected outputs are derived from that queue with plain arithmetic.
module tb_draw_menu;
  localparam int ADDR_W   = 14;
  localparam int MAX_ADDR = 128 * 96 - 1;

  // Clock/reset
  logic clk = 1'b0;
  logic rst;
  logic start_game;
  logic [11:0] rgb_pixel;
  logic [ADDR_W-1:0] pixel_addr;

  vga_if vin();
  vga_if vout();

  initial forever #5 clk = ~clk;

  draw_menu dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .in         (vin),
    .out        (vout)
  );

  int checks = 0;
  int errors = 0;

  // Image ROM stand-in. The content is an arbitrary hash of the address.
  // rom_force makes the ROM return white.
  logic rom_force = 1'b0;
  logic last_force = 1'b0;

  function automatic logic [11:0] rom_f(input int a);
    int t;
    t = a * 29 + (a >> 5) * 3 + 53;
    return t[11:0];
  endfunction

  always @(posedge clk) rgb_pixel <= rom_force ? 12'hFFF : rom_f(int'(pixel_addr));

  // Reference model
  typedef struct {
    logic        z;   // record standing for a reset slot: everything zero
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        sg;
  } rec_t;

  rec_t hist[$];
  rec_t zr;

  function automatic logic in_img(input rec_t r);
    return (r.h / 8 < 128) && (r.v / 8 < 96);
  endfunction

  function automatic int img_addr(input rec_t r);
    return (r.v / 8) * 128 + r.h / 8;
  endfunction

  always @(posedge clk) begin
    rec_t cur;
    cur.z   = 1'b0;
    cur.h   = int'(vin.hcount);
    cur.v   = int'(vin.vcount);
    cur.hs  = vin.hsync;
    cur.vs  = vin.vsync;
    cur.hb  = vin.hblnk;
    cur.vb  = vin.vblnk;
    cur.rgb = vin.rgb;
    cur.sg  = start_game;
    if (rst) begin
      hist = '{zr, zr};
    end else begin
      hist.push_back(cur);
      void'(hist.pop_front());
    end
    last_force = rom_force;
  end

  // Scoreboard
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    rec_t r;
    rec_t a;
    int exp_rgb;
    r = hist[0];
    a = hist[1];
    if (r.z) begin
      exp_rgb = 0;
    end else if (r.hb || r.vb) begin
      exp_rgb = 0;
    end else if (r.sg) begin
      exp_rgb = int'(r.rgb);
    end else if (in_img(r)) begin
      exp_rgb = last_force ? 'hFFF : int'(rom_f(img_addr(r)));
    end else begin
      exp_rgb = int'(r.rgb);
    end
    chk("hcount", int'(vout.hcount), r.z ? 0 : r.h);
    chk("vcount", int'(vout.vcount), r.z ? 0 : r.v);
    chk("hsync",  int'(vout.hsync),  r.z ? 0 : int'(r.hs));
    chk("vsync",  int'(vout.vsync),  r.z ? 0 : int'(r.vs));
    chk("hblnk",  int'(vout.hblnk),  r.z ? 0 : int'(r.hb));
    chk("vblnk",  int'(vout.vblnk),  r.z ? 0 : int'(r.vb));
    chk("rgb",    int'(vout.rgb),    exp_rgb);
    if (a.z)            chk("addr_rst", int'(pixel_addr), 0);
    else if (in_img(a)) chk("addr",     int'(pixel_addr), img_addr(a));
    else                chk("addr_bound", int'(int'(pixel_addr) <= MAX_ADDR), 1);
  endtask

  // Driver tasks
  task automatic drive(input int h, input int v, input logic [11:0] c, input logic sg);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = (h >= 1024);
    vin.vblnk  = (v >= 768);
    vin.hsync  = (h >= 1048) && (h < 1184);
    vin.vsync  = (v >= 771) && (v < 777);
    vin.rgb    = c;
    start_game = sg;
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    int h;
    int v;
    logic sg;
    zr = '{default: 0};
    zr.z = 1'b1;
    hist = '{zr, zr};

    // Reset held with a busy input: everything must read zero.
    rst = 1'b1;
    drive(1100, 770, 12'hABC, 1'b0);
    step();
    step();
    chk("rst_hcount", int'(vout.hcount), 0);
    chk("rst_hsync",  int'(vout.hsync), 0);
    chk("rst_hblnk",  int'(vout.hblnk), 0);
    chk("rst_addr",   int'(pixel_addr), 0);

    // Release: out trails in by two clocks.
    rst = 1'b0;
    drive(500, 10, 12'h111, 1'b0);
    step();
    drive(501, 10, 12'h222, 1'b0);
    step();
    chk("lat_hcount", int'(vout.hcount), 500);
    chk("lat_vcount", int'(vout.vcount), 10);

    // Origin pixel: address 0, then ROM[0] on rgb.
    drive(0, 0, 12'h555, 1'b0);
    step();
    chk("addr_origin", int'(pixel_addr), 0);
    drive(1, 0, 12'h555, 1'b0);
    step();
    chk("rgb_rom0", int'(vout.rgb), 'h035);

    // Corner and interior addresses
    drive(1023, 767, 12'h000, 1'b0);
    step();
    chk("addr_corner", int'(pixel_addr), 12287);
    drive(8, 8, 12'h000, 1'b0);
    step();
    chk("addr_8_8", int'(pixel_addr), 129);

    // Blanking with white ROM data: black out, hsync delayed 2.
    rom_force = 1'b1;
    drive(1100, 100, 12'h123, 1'b0);
    step();
    drive(1101, 100, 12'h123, 1'b0);
    step();
    chk("blank_rgb",   int'(vout.rgb), 0);
    chk("blank_hsync", int'(vout.hsync), 1);
    chk("blank_hblnk", int'(vout.hblnk), 1);
    drive(16, 16, 12'h123, 1'b0);
    step();
    drive(17, 16, 12'h123, 1'b0);
    step();
    chk("img_white", int'(vout.rgb), 'hFFF);
    rom_force = 1'b0;

    // Game running: in.rgb passes, ROM ignored.
    drive(200, 200, 12'hABC, 1'b1);
    step();
    drive(201, 200, 12'h000, 1'b1);
    step();
    chk("game_rgb", int'(vout.rgb), 'hABC);

    // Mid-frame reset
    drive(300, 300, 12'h321, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_hcount", int'(vout.hcount), 0);
    chk("mid_rst_addr",   int'(pixel_addr), 0);
    rst = 1'b0;

    // Random scan starting just before the frame wrap, with jumps, toggles and rare resets
    h = 1338;
    v = 804;
    sg = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 1343);
        v = $urandom_range(0, 805);
      end else begin
        h++;
        if (h == 1344) begin
          h = 0;
          v = (v == 805) ? 0 : v + 1;
        end
      end
      if ($urandom_range(0, 15) == 0) sg = ~sg;
      drive(h, v, 12'($urandom_range(0, 4095)), sg);
      step();
    end
    rst = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
